// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : RV32I single-register decode stage with a valid/ready
//               handshake and load-use hazard bubbling.
// Revision    : 1.0 - initial release
// ============================================================================

module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic            out_regwrite,
  output logic            out_memread,
  output logic            out_memwrite,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_alusrc,
  output logic            out_illegal
);

  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_opimm  = 7'b0010011;
  localparam logic [6:0] c_op_op     = 7'b0110011;

  // Combinational decode of the incoming instruction
  logic [6:0]      w_opcode;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm;
  logic            w_regwrite;
  logic            w_memread;
  logic            w_memwrite;
  logic            w_branch;
  logic            w_jump;
  logic            w_alusrc;
  logic            w_illegal;
  logic            w_rs1_used;
  logic            w_rs2_used;
  logic            w_hazard;
  logic            w_in_ready;
  logic            w_accept;

  assign w_opcode = in_instr[6:0];
  assign w_rs1    = in_instr[19:15];
  assign w_rs2    = in_instr[24:20];
  assign w_rd     = in_instr[11:7];

  assign w_imm_i = {{(XLEN-11){in_instr[31]}}, in_instr[30:20]};
  assign w_imm_s = {{(XLEN-11){in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
  assign w_imm_b = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
  assign w_imm_j = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};

  always_comb begin
    w_imm      = '0;
    w_regwrite = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_branch   = 1'b0;
    w_jump     = 1'b0;
    w_alusrc   = 1'b0;
    w_illegal  = 1'b0;
    case (w_opcode)
      c_op_lui, c_op_auipc: begin
        w_imm      = w_imm_u;
        w_regwrite = 1'b1;
        w_alusrc   = 1'b1;
      end
      c_op_jal: begin
        w_imm      = w_imm_j;
        w_jump     = 1'b1;
        w_regwrite = 1'b1;
      end
      c_op_jalr: begin
        w_imm      = w_imm_i;
        w_jump     = 1'b1;
        w_regwrite = 1'b1;
        w_alusrc   = 1'b1;
      end
      c_op_branch: begin
        w_imm    = w_imm_b;
        w_branch = 1'b1;
      end
      c_op_load: begin
        w_imm      = w_imm_i;
        w_memread  = 1'b1;
        w_regwrite = 1'b1;
        w_alusrc   = 1'b1;
      end
      c_op_store: begin
        w_imm      = w_imm_s;
        w_memwrite = 1'b1;
        w_alusrc   = 1'b1;
      end
      c_op_opimm: begin
        w_imm      = w_imm_i;
        w_regwrite = 1'b1;
        w_alusrc   = 1'b1;
      end
      c_op_op: begin
        w_regwrite = 1'b1;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
    // Writes to x0 are architecturally discarded
    if (w_rd == 5'd0) begin
      w_regwrite = 1'b0;
    end
  end

  assign w_rs1_used = !((w_opcode == c_op_lui) || (w_opcode == c_op_auipc) ||
                        (w_opcode == c_op_jal));
  assign w_rs2_used = (w_opcode == c_op_branch) || (w_opcode == c_op_store) ||
                      (w_opcode == c_op_op);

  // Registered bundle
  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_imm;
  logic            r_regwrite;
  logic            r_memread;
  logic            r_memwrite;
  logic            r_branch;
  logic            r_jump;
  logic            r_alusrc;
  logic            r_illegal;

  // Load result is not available yet when the consumer would read registers
  assign w_hazard = in_valid && r_valid && r_memread && (r_rd != 5'd0) &&
                    ((w_rs1_used && (r_rd == w_rs1)) ||
                     (w_rs2_used && (r_rd == w_rs2)));

  assign w_in_ready = !reset && !w_hazard && !flush && (!r_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_imm      <= '0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_branch   <= 1'b0;
      r_jump     <= 1'b0;
      r_alusrc   <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_pc       <= in_pc;
      r_rs1      <= w_rs1;
      r_rs2      <= w_rs2;
      r_rd       <= w_rd;
      r_imm      <= w_imm;
      r_regwrite <= w_regwrite;
      r_memread  <= w_memread;
      r_memwrite <= w_memwrite;
      r_branch   <= w_branch;
      r_jump     <= w_jump;
      r_alusrc   <= w_alusrc;
      r_illegal  <= w_illegal;
    end else if (r_valid && out_ready) begin
      // Drained with nothing to replace it; this is also the hazard bubble
      r_valid <= 1'b0;
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = r_valid;
  assign out_pc       = r_pc;
  assign out_rs1      = r_rs1;
  assign out_rs2      = r_rs2;
  assign out_rd       = r_rd;
  assign out_imm      = r_imm;
  assign out_regwrite = r_regwrite;
  assign out_memread  = r_memread;
  assign out_memwrite = r_memwrite;
  assign out_branch   = r_branch;
  assign out_jump     = r_jump;
  assign out_alusrc   = r_alusrc;
  assign out_illegal  = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Scoreboard bench for decode_stage.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  logic        out_regwrite;
  logic        out_memread;
  logic        out_memwrite;
  logic        out_branch;
  logic        out_jump;
  logic        out_alusrc;
  logic        out_illegal;

  decode_stage #(.XLEN(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_rd       (out_rd),
    .out_imm      (out_imm),
    .out_regwrite (out_regwrite),
    .out_memread  (out_memread),
    .out_memwrite (out_memwrite),
    .out_branch   (out_branch),
    .out_jump     (out_jump),
    .out_alusrc   (out_alusrc),
    .out_illegal  (out_illegal)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Bundle = {pc, imm, rs1, rs2, rd, flags}; flags = {rw, mr, mw, br, jp, as, il}
  logic [85:0] sb[$];
  logic [85:0] mon_exp;
  logic [6:0]  act_flags;
  logic [85:0] act_bundle;

  assign act_flags  = {out_regwrite, out_memread, out_memwrite, out_branch,
                       out_jump, out_alusrc, out_illegal};
  assign act_bundle = {out_pc, out_imm, out_rs1, out_rs2, out_rd, act_flags};

  function automatic logic [85:0] bundle(input logic [31:0] pc, input logic [31:0] imm,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [4:0] rd, input logic [6:0] fl);
    return {pc, imm, rs1, rs2, rd, fl};
  endfunction

  // Every downstream transfer must match the oldest expected bundle
  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %h, required no output", act_bundle);
      end else begin
        mon_exp = sb.pop_front();
        if (act_bundle !== mon_exp) begin
          errors++;
          $display("FAIL bundle: got %h, required %h", act_bundle, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(32'hFFF00293, 32'h0000_0040);
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    checks++; if (act_flags !== 7'd0) begin errors++; $display("FAIL rst_flags: got %b, required 0000000", act_flags); end
    checks++; if (out_pc !== 32'd0) begin errors++; $display("FAIL rst_pc: got %h, required 0", out_pc); end
    checks++; if (out_imm !== 32'd0) begin errors++; $display("FAIL rst_imm: got %h, required 0", out_imm); end
    checks++; if ({out_rs1, out_rs2, out_rd} !== 15'd0) begin
      errors++; $display("FAIL rst_regs: got %h, required 0", {out_rs1, out_rs2, out_rd});
    end
    in_valid = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    drive(32'hFFF00293, 32'h0000_0100);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL addi_in_ready: got %b, required 1", in_ready); end
    sb.push_back(bundle(32'h100, 32'hFFFF_FFFF, 5'd0, 5'd31, 5'd5, 7'b1000010));
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_latency: got %b, required 1", out_valid); end
    checks++; if (out_rd !== 5'd5) begin errors++; $display("FAIL addi_rd: got %0d, required 5", out_rd); end
    checks++; if (out_imm !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addi_imm: got %h, required ffffffff", out_imm); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b, required 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [9] = '{32'h123451B7, 32'h008000EF, 32'h0020A223, 32'h00008067,
                             32'hFFFFF517, 32'h0000007F, 32'h00100013, 32'hFE20AC23,
                             32'hFE208EE3};
    logic [31:0] imm [9] = '{32'h12345000, 32'h8, 32'h4, 32'h0, 32'hFFFFF000, 32'h0,
                             32'h1, 32'hFFFFFFF8, 32'hFFFFFFFC};
    logic [4:0]  rs1 [9] = '{5'd8, 5'd0, 5'd1, 5'd1, 5'd31, 5'd0, 5'd0, 5'd1, 5'd1};
    logic [4:0]  rs2 [9] = '{5'd3, 5'd8, 5'd2, 5'd0, 5'd31, 5'd0, 5'd1, 5'd2, 5'd2};
    logic [4:0]  rd  [9] = '{5'd3, 5'd1, 5'd4, 5'd0, 5'd10, 5'd0, 5'd0, 5'd24, 5'd29};
    logic [6:0]  fl  [9] = '{7'b1000010, 7'b1000100, 7'b0010010, 7'b0000110, 7'b1000010,
                             7'b0000001, 7'b0000010, 7'b0010010, 7'b0001000};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(ins[i], 32'h1000 + 32'(4 * i));
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_in_ready[%0d]: got %b, required 1", i, in_ready);
      end
      sb.push_back(bundle(32'h1000 + 32'(4 * i), imm[i], rs1[i], rs2[i], rd[i], fl[i]));
      tick();
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_load_use();
    out_ready = 1'b1;
    drive(32'h0000A303, 32'h200);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lw_in_ready: got %b, required 1", in_ready); end
    sb.push_back(bundle(32'h200, 32'h0, 5'd1, 5'd0, 5'd6, 7'b1100010));
    tick();
    drive(32'h002303B3, 32'h204);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_in_ready: got %b, required 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid: got %b, required 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_bubble_ready: got %b, required 1", in_ready); end
    sb.push_back(bundle(32'h204, 32'h0, 5'd6, 5'd2, 5'd7, 7'b1000000));
    tick();
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd7) begin
      errors++; $display("FAIL add_emitted: got valid=%b rd=%0d, required valid=1 rd=7", out_valid, out_rd);
    end
    // Load followed by an instruction whose unused rs2 field matches rd
    drive(32'h0000AF83, 32'h208);
    #1;
    sb.push_back(bundle(32'h208, 32'h0, 5'd1, 5'd0, 5'd31, 7'b1100010));
    tick();
    drive(32'hFFF00293, 32'h20C);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL unused_rs2_no_hazard: got %b, required 1", in_ready); end
    sb.push_back(bundle(32'h20C, 32'hFFFF_FFFF, 5'd0, 5'd31, 5'd5, 7'b1000010));
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive(32'hFFF00293, 32'h300);
    #1;
    sb.push_back(bundle(32'h300, 32'hFFFF_FFFF, 5'd0, 5'd31, 5'd5, 7'b1000010));
    tick();
    drive(32'h123451B7, 32'h304);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h300 || out_imm !== 32'hFFFF_FFFF) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got ready=%b valid=%b pc=%h imm=%h, required ready=0 valid=1 pc=300 imm=ffffffff",
                 c, in_ready, out_valid, out_pc, out_imm);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b, required 1", in_ready); end
    sb.push_back(bundle(32'h304, 32'h12345000, 5'd8, 5'd3, 5'd3, 7'b1000010));
    tick();
    in_valid = 1'b0;
    checks++; if (out_pc !== 32'h304) begin errors++; $display("FAIL release_pc: got %h, required 304", out_pc); end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(32'h0000A303, 32'h400);
    tick();
    in_valid = 1'b0;
    tick();
    drive(32'h002303B3, 32'h404);
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b, required 0", in_ready); end
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b, required 0", out_valid); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_accept: got %b, required 0", out_valid); end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    drive(32'hFFF00293, 32'h500);
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    drive(32'h123451B7, 32'h504);
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_stall_reset: got valid=%b ready=%b, required 0 0", out_valid, in_ready);
    end
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL first_after_reset: got %b, required 1", in_ready); end
    sb.push_back(bundle(32'h504, 32'h12345000, 5'd8, 5'd3, 5'd3, 7'b1000010));
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h504) begin
      errors++; $display("FAIL post_reset_out: got valid=%b pc=%h, required 1 504", out_valid, out_pc);
    end
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    test_reset();
    test_addi();
    test_back_to_back();
    test_load_use();
    test_stall();
    test_flush();
    test_reset_mid_stall();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_empty: got %0d pending, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameters: XLEN, 32, datapath width; only 32 is supported.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  reset, synchronous, active-high; clock clk.
REQ-004 in_valid  in  1  fetch presents an instruction.
REQ-005 in_ready  out  1  decode accepts the instruction this cycle (combinational).
REQ-006 in_instr  in  32  RV32I instruction word.
REQ-007 in_pc  in  32  PC of in_instr.
REQ-008 flush  in  1  discard the held and the incoming instruction.
REQ-009 out_valid  out  1  decoded bundle valid.
REQ-010 out_ready  in  1  downstream (register-file read / execute) accepts the bundle.
REQ-011 out_pc  out  32  registered PC.
REQ-012 out_rs1, out_rs2, out_rd  out  5 each  instr[19:15], instr[24:20], instr[11:7]; these drive the register-file read and write addresses.
REQ-013 out_imm  out  32  sign-extended immediate.
REQ-014 out_regwrite, out_memread, out_memwrite, out_branch, out_jump, out_alusrc, out_illegal  out  1 each  control flags.

Function
REQ-015 The block SHALL be a single registered stage with a valid/ready handshake; a transfer occurs on a rising edge where valid and ready are both 1.
REQ-016 in_ready SHALL equal !hazard && !flush && (!out_valid || out_ready).
REQ-017 On an input transfer the block SHALL register the decoded bundle and set out_valid=1, giving 1-cycle latency.
REQ-018 When out_valid && out_ready and no input transfer occurs, out_valid SHALL clear to 0 on the next edge.
REQ-019 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-020 Opcode decode for LUI 0110111 and AUIPC 0010111: U-immediate {instr[31:12],12'b0}, regwrite=1, alusrc=1.
REQ-021 Opcode decode for JAL 1101111: J-immediate, jump=1, regwrite=1.
REQ-022 Opcode decode for JALR 1100111: I-immediate, jump=1, regwrite=1, alusrc=1.
REQ-023 Opcode decode for BRANCH 1100011: B-immediate with bit0=0, branch=1.
REQ-024 Opcode decode for LOAD 0000011: I-immediate, memread=1, regwrite=1, alusrc=1.
REQ-025 Opcode decode for STORE 0100011: S-immediate, memwrite=1, alusrc=1.
REQ-026 Opcode decode for OP-IMM 0010011: I-immediate, regwrite=1, alusrc=1.
REQ-027 Opcode decode for OP 0110011: imm=0, regwrite=1.
REQ-028 Any other opcode SHALL set illegal=1 with all other control flags 0 and imm=0.
REQ-029 rd=0 SHALL force out_regwrite=0.
REQ-030 All immediates SHALL be sign-extended from instr[31].
REQ-031 rs1 is used by all opcodes except LUI, AUIPC and JAL; rs2 is used by BRANCH, STORE and OP.
REQ-032 hazard SHALL be asserted when in_valid, out_valid, out_memread and out_rd!=0 all hold, and out_rd equals a used rs1 or rs2 of in_instr.
REQ-033 During a hazard, if out_ready=1 the block SHALL load a bubble (out_valid=0) so the instruction is accepted one cycle later; if out_ready=0 the outputs SHALL hold.
REQ-034 flush SHALL clear out_valid to 0 on the next edge regardless of out_ready; flush has priority over hazard and handshake.

Reset
REQ-035 During reset, out_valid SHALL be 0, all control flags 0, and out_pc, out_imm, out_rs1, out_rs2 and out_rd 0; in_ready SHALL be 0 while reset is asserted.
REQ-036 A reset mid-stall SHALL drop the held bundle; the first valid instruction after reset deasserts SHALL be accepted on the first cycle.

Verification
REQ-037 addi x5,x0,-1 (0xFFF00293), pc=0x100 -> next cycle out_valid=1, rd=5, imm=0xFFFFFFFF, regwrite=1, alusrc=1.
REQ-038 lw x6,0(x1) then add x7,x6,x2 back-to-back with out_ready=1 -> one bubble cycle (out_valid=0), add emitted on the following cycle.
REQ-039 beq x1,x2,-4 (0xFE208EE3) -> branch=1, imm=0xFFFFFFFC, regwrite=0.
REQ-040 out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0 and the bundle is stable; on release the next instruction is accepted.
REQ-041 flush while stalled holding lw -> next cycle out_valid=0 and the incoming instruction is not accepted.
REQ-042 Opcode 0x0000007F -> illegal=1, all other flags 0; addi x0,x0,1 -> regwrite=0.
